// File: rtl/i2c_init_seq.sv
// Walks a register-init table and issues one I2C write per entry, with retries,
// per-transaction timeouts, inter-transaction gaps, delay entries and an end marker.
module i2c_init_seq #(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned DELAY_UNIT     = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_start,
  output logic [7:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic [23:0] i2c_data,
  output logic        i2c_start,
  output logic        i2c_wr,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_error,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_fail,
  output logic [7:0]  fail_index
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW   = $clog2(GAP_CYCLES);
  localparam int unsigned UnitW  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    StIdle, StFetch, StLoad, StReq, StWaitResp, StRelease, StGap, StDelay, StDone, StFail
  } state_e;

  state_e            state_q, state_d;
  logic              init_start_q;
  logic [8:0]        index_q, index_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [UnitW-1:0]  unit_q, unit_d;
  logic [15:0]       units_q, units_d;
  logic              err_q, err_d;
  logic [7:0]        tbl_addr_q, tbl_addr_d;
  logic [23:0]       i2c_data_q, i2c_data_d;
  logic              i2c_start_q, i2c_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [7:0]        fail_index_q, fail_index_d;

  logic              start_edge;
  logic [8:0]        index_inc;
  logic [RetryW-1:0] retry_inc;

  assign start_edge = init_start & ~init_start_q;
  assign index_inc  = index_q + 9'd1;
  assign retry_inc  = retry_q + RetryW'(1);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    unit_d       = unit_q;
    units_d      = units_q;
    err_d        = err_q;
    i2c_data_d   = i2c_data_q;
    i2c_start_d  = i2c_start_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_index_d = fail_index_q;

    case (state_q)
      StIdle, StDone, StFail: begin
        i2c_start_d = 1'b0;
        if (start_edge) begin
          index_d      = '0;
          retry_d      = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_index_d = '0;
          busy_d       = 1'b1;
          state_d      = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        if (tbl_data == 24'hFFFFFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (tbl_data[23:16] == 8'hFE) begin
          units_d = tbl_data[15:0];
          unit_d  = '0;
          state_d = StDelay;
        end else begin
          // Data is registered a cycle ahead of the request so it is stable when start rises.
          i2c_data_d = tbl_data;
          state_d    = StReq;
        end
      end
      StReq: begin
        i2c_start_d = 1'b1;
        tmo_d       = '0;
        state_d     = StWaitResp;
      end
      StWaitResp: begin
        if (i2c_done || i2c_error) begin
          err_d       = i2c_error;
          i2c_start_d = 1'b0;
          tmo_d       = '0;
          state_d     = StRelease;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
          err_d       = 1'b1;
          i2c_start_d = 1'b0;
          tmo_d       = '0;
          state_d     = StRelease;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRelease: begin
        if (!(i2c_done || i2c_error || i2c_busy)) begin
          gap_d = '0;
          if (!err_q) begin
            retry_d = '0;
            index_d = index_inc;
            state_d = StGap;
          end else if (retry_inc > RetryW'(MAX_RETRY)) begin
            retry_d      = retry_inc;
            busy_d       = 1'b0;
            fail_d       = 1'b1;
            fail_index_d = index_q[7:0];
            state_d      = StFail;
          end else begin
            retry_d = retry_inc;
            state_d = StGap;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
          // Master never went idle: treat as a hard failure of this entry.
          busy_d       = 1'b0;
          fail_d       = 1'b1;
          fail_index_d = index_q[7:0];
          state_d      = StFail;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          gap_d = '0;
          if (index_q == 9'(NUM_REGS)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StDelay: begin
        if (units_q == '0) begin
          index_d = index_inc;
          if (index_inc == 9'(NUM_REGS)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end else if (unit_q == UnitW'(DELAY_UNIT - 1)) begin
          unit_d  = '0;
          units_d = units_q - 16'd1;
        end else begin
          unit_d = unit_q + UnitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Address tracks the index so table data is already valid by the LOAD cycle.
    tbl_addr_d = index_d[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      init_start_q <= 1'b0;
      index_q      <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      unit_q       <= '0;
      units_q      <= '0;
      err_q        <= 1'b0;
      tbl_addr_q   <= '0;
      i2c_data_q   <= '0;
      i2c_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      init_start_q <= init_start;
      index_q      <= index_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      unit_q       <= unit_d;
      units_q      <= units_d;
      err_q        <= err_d;
      tbl_addr_q   <= tbl_addr_d;
      i2c_data_q   <= i2c_data_d;
      i2c_start_q  <= i2c_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign tbl_addr   = tbl_addr_q;
  assign i2c_data   = i2c_data_q;
  assign i2c_start  = i2c_start_q;
  assign i2c_wr     = 1'b1;
  assign init_busy  = busy_q;
  assign init_done  = done_q;
  assign init_fail  = fail_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: table walks, retries, failure, delay entries,
// end marker, timeout and asynchronous reset, against a simple I2C master model.
module tb_i2c_init_seq;

  localparam int unsigned NumRegs   = 4;
  localparam int unsigned MaxRetry  = 3;
  localparam int unsigned GapCycles = 8;
  localparam int unsigned TmoCycles = 50;
  localparam int unsigned DelayUnit = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_start;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic [23:0] i2c_data;
  logic        i2c_start;
  logic        i2c_wr;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_error;
  logic        init_busy;
  logic        init_done;
  logic        init_fail;
  logic [7:0]  fail_index;

  always #5 clk = ~clk;

  i2c_init_seq #(
    .NUM_REGS      (NumRegs),
    .MAX_RETRY     (MaxRetry),
    .GAP_CYCLES    (GapCycles),
    .TIMEOUT_CYCLES(TmoCycles),
    .DELAY_UNIT    (DelayUnit)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_start(init_start),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .i2c_data  (i2c_data),
    .i2c_start (i2c_start),
    .i2c_wr    (i2c_wr),
    .i2c_busy  (i2c_busy),
    .i2c_done  (i2c_done),
    .i2c_error (i2c_error),
    .init_busy (init_busy),
    .init_done (init_done),
    .init_fail (init_fail),
    .fail_index(fail_index)
  );

  int checks = 0;
  int failures = 0;

  // Written by the main sequence only.
  logic [23:0] tbl [0:255];
  logic        silent;
  logic [23:0] err_word;
  int          err_limit;
  int          walk_id;

  // Written by the master model only.
  int          cyc, tx_count, err_used, min_gap, last_rise, last_fall, last_high, done_cyc;
  int          seen_id, max_addr, m_cnt;
  logic [23:0] tx_log [0:15];
  logic [23:0] cur_word, prev_data;
  logic        prev_start, prev_done, data_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_walk(input string tag, input int budget);
    int n;
    @(negedge clk);
    walk_id++;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    check({tag, "_busy"}, init_busy, 1);
    n = 0;
    while (!(init_done || init_fail) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, n < budget, 1);
  endtask

  // Master model and table memory, updated on the falling edge.
  initial begin
    i2c_busy = 1'b0; i2c_done = 1'b0; i2c_error = 1'b0; tbl_data = '0;
    cyc = 0; tx_count = 0; err_used = 0; min_gap = 1 << 30; last_rise = 0; last_fall = 0;
    last_high = 0; done_cyc = 0; seen_id = 0; max_addr = 0; m_cnt = 0;
    cur_word = '0; prev_data = '0; prev_start = 1'b0; prev_done = 1'b0; data_bad = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (walk_id != seen_id) begin
        seen_id = walk_id; tx_count = 0; err_used = 0; min_gap = 1 << 30;
        max_addr = 0; data_bad = 1'b0;
      end
      tbl_data = tbl[tbl_addr];
      if (init_busy && int'(tbl_addr) > max_addr) max_addr = int'(tbl_addr);
      if (init_done && !prev_done) done_cyc = cyc;
      if (i2c_start && !prev_start) begin
        if (i2c_data !== prev_data) data_bad = 1'b1;
        if (tx_count > 0 && cyc - last_fall < min_gap) min_gap = cyc - last_fall;
        if (tx_count < 16) tx_log[tx_count] = i2c_data;
        tx_count++;
        last_rise = cyc;
        cur_word  = i2c_data;
        if (!silent) begin
          i2c_busy = 1'b1;
          m_cnt    = 3;
        end
      end else if (!i2c_start && prev_start) begin
        last_fall = cyc;
        last_high = cyc - last_rise;
      end
      if (i2c_start && i2c_data !== cur_word) data_bad = 1'b1;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i2c_busy = 1'b0;
          if (cur_word == err_word && (err_limit < 0 || err_used < err_limit)) begin
            i2c_error = 1'b1;
            err_used++;
          end else begin
            i2c_done = 1'b1;
          end
        end
      end else if (!i2c_start) begin
        i2c_done  = 1'b0;
        i2c_error = 1'b0;
      end
      prev_start = i2c_start;
      prev_data  = i2c_data;
      prev_done  = init_done;
    end
  end

  initial begin
    logic [23:0] exp_b [0:5];
    int n;
    reset_n = 1'b0; init_start = 1'b0; silent = 1'b0;
    err_word = '0; err_limit = 0; walk_id = 0;
    for (int i = 0; i < 256; i++) tbl[i] = 24'hFFFFFF;
    repeat (3) @(negedge clk);

    check("reset_ctrl", {i2c_start, i2c_wr, init_busy, init_done, init_fail}, 5'b01000);
    check("reset_data", i2c_data, 0);
    check("reset_addr_idx", {tbl_addr, fail_index}, 0);
    reset_n = 1'b1;

    // Three entries then the end marker, all acknowledged.
    tbl[0] = 24'h301011; tbl[1] = 24'h302022; tbl[2] = 24'h303033; tbl[3] = 24'hFFFFFF;
    run_walk("basic", 300);
    check("basic_count", tx_count, 3);
    check("basic_tx0", tx_log[0], 24'h301011);
    check("basic_tx1", tx_log[1], 24'h302022);
    check("basic_tx2", tx_log[2], 24'h303033);
    check("basic_gap", min_gap >= int'(GapCycles), 1);
    check("basic_flags", {init_busy, init_done, init_fail}, 3'b010);
    check("basic_data_stable", data_bad, 0);

    // Four real entries (walk ends on the entry count); entry 1 errors twice.
    tbl[1] = 24'h305055; tbl[3] = 24'h304044;
    err_word = 24'h305055; err_limit = 2;
    exp_b[0] = 24'h301011; exp_b[1] = 24'h305055; exp_b[2] = 24'h305055;
    exp_b[3] = 24'h305055; exp_b[4] = 24'h303033; exp_b[5] = 24'h304044;
    run_walk("retry", 400);
    check("retry_count", tx_count, 6);
    for (int i = 0; i < 6; i++) check($sformatf("retry_tx%0d", i), tx_log[i], exp_b[i]);
    check("retry_flags", {init_busy, init_done, init_fail}, 3'b010);

    // Entry 2 always errors: MAX_RETRY+1 attempts then abort.
    tbl[1] = 24'h302022; tbl[2] = 24'h30AAAA;
    err_word = 24'h30AAAA; err_limit = -1;
    run_walk("abort", 400);
    check("abort_count", tx_count, 2 + MaxRetry + 1);
    check("abort_flags", {init_busy, init_done, init_fail}, 3'b001);
    check("abort_index", fail_index, 2);
    check("abort_max_addr", max_addr, 2);

    // Delay entry of 3 units, then the end marker.
    err_limit = 0;
    tbl[1] = 24'hFE0003; tbl[2] = 24'hFFFFFF;
    run_walk("delay", 300);
    check("delay_count", tx_count, 1);
    check("delay_flags", {init_busy, init_done, init_fail}, 3'b010);
    check("delay_quiet", (done_cyc - last_fall >= 38) && (done_cyc - last_fall <= 50), 1);

    // Silent master: timeout, retry, then reset mid-transaction.
    silent = 1'b1;
    tbl[1] = 24'h302022;
    @(negedge clk);
    walk_id++;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    n = 0;
    while (tx_count < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tmo_attempts", tx_count, 2);
    check("tmo_high_len", (last_high >= 50) && (last_high <= 52), 1);
    check("tmo_retry_word", tx_log[1], 24'h301011);
    repeat (5) @(negedge clk);
    check("tmo_start_held", i2c_start, 1);
    reset_n = 1'b0;
    #1;
    check("arst_ctrl", {i2c_start, i2c_wr, init_busy, init_done, init_fail}, 5'b01000);
    check("arst_data", i2c_data, 0);
    check("arst_addr_idx", {tbl_addr, fail_index}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume", {i2c_start, init_busy}, 2'b00);
    check("no_resume_tx", tx_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
